// File: rtl/lr2_seq_tracker_fsm.sv
// LR2 sequence tracker: decodes the SEQ stream, locks onto the counter position and direction,
// and flags/counts out-of-sequence samples. Optional macro LR2_TRK_LOAD_EN adds the LOAD input.
module lr2_seq_tracker_fsm #(
  parameter int unsigned LOCK_CNT = 2,
  parameter int unsigned MISS_MAX = 3,
  parameter int unsigned ERRW     = 8
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            CE,
  input  logic [3:0]      SEQ,
  input  logic            SYNC_REQ,
`ifdef LR2_TRK_LOAD_EN
  input  logic            LOAD,
`endif
  output logic [3:0]      POS,
  output logic            DIR,
  output logic            LOCK,
  output logic            ERR,
  output logic            DIR_CHG,
  output logic [ERRW-1:0] ERR_CNT
);

  typedef enum logic [1:0] {
    S_HUNT = 2'd0,
    S_ACQ  = 2'd1,
    S_CONF = 2'd2,
    S_LOCK = 2'd3
  } state_t;

  localparam logic [3:0] LOCK_CNT4 = LOCK_CNT[3:0];
  localparam logic [3:0] MISS_MAX4 = MISS_MAX[3:0];

  state_t            state_q, state_n;
  logic [3:0]        pos_q, pos_n;
  logic              dir_q, dir_n;
  logic              err_q, err_n;
  logic              dchg_q, dchg_n;
  logic [ERRW-1:0]   errc_q, errc_n;
  logic [3:0]        cnt_q, cnt_n;
  logic [3:0]        miss_q, miss_n;
  logic [3:0]        dec;
  logic [3:0]        d;
  logic [3:0]        fwd;
  logic [3:0]        rev;
  logic [3:0]        cnt_inc;
  logic [3:0]        miss_inc;

  // Inverse of the LR2_OUT encoding (reflected Gray code).
  always_comb begin
    dec = 4'h0;
    case (SEQ)
      4'h0: dec = 4'h0;
      4'h1: dec = 4'h1;
      4'h2: dec = 4'h3;
      4'h3: dec = 4'h2;
      4'h4: dec = 4'h7;
      4'h5: dec = 4'h6;
      4'h6: dec = 4'h4;
      4'h7: dec = 4'h5;
      4'h8: dec = 4'hF;
      4'h9: dec = 4'hE;
      4'hA: dec = 4'hC;
      4'hB: dec = 4'hD;
      4'hC: dec = 4'h8;
      4'hD: dec = 4'h9;
      4'hE: dec = 4'hB;
      4'hF: dec = 4'hA;
      default: dec = 4'h0;
    endcase
  end

  always_comb begin
    d        = dec - pos_q;
    fwd      = dir_q ? 4'h1 : 4'hF;
    rev      = dir_q ? 4'hF : 4'h1;
    cnt_inc  = cnt_q + 4'h1;
    miss_inc = miss_q + 4'h1;

    state_n = state_q;
    pos_n   = pos_q;
    dir_n   = dir_q;
    err_n   = 1'b0;
    dchg_n  = 1'b0;
    errc_n  = errc_q;
    cnt_n   = cnt_q;
    miss_n  = miss_q;

    if (SYNC_REQ) begin
      state_n = S_HUNT;
      miss_n  = '0;
      cnt_n   = '0;
    end else if (CE) begin
`ifdef LR2_TRK_LOAD_EN
      if (LOAD) begin
        pos_n  = dec;
        miss_n = '0;
        if (state_q != S_LOCK) begin
          state_n = S_ACQ;
          cnt_n   = '0;
        end
      end else begin
`endif
      case (state_q)
        S_HUNT: begin
          pos_n   = dec;
          state_n = S_ACQ;
        end
        S_ACQ: begin
          if (d == 4'h1 || d == 4'hF) begin
            dir_n   = (d == 4'h1);
            pos_n   = dec;
            cnt_n   = 4'h1;
            state_n = (LOCK_CNT4 == 4'h1) ? S_LOCK : S_CONF;
          end else if (d != 4'h0) begin
            pos_n = dec;
          end
        end
        S_CONF: begin
          if (d == fwd) begin
            pos_n = dec;
            cnt_n = cnt_inc;
            if (cnt_inc == LOCK_CNT4) state_n = S_LOCK;
          end else if (d != 4'h0) begin
            pos_n   = dec;
            cnt_n   = '0;
            state_n = S_ACQ;
          end
        end
        S_LOCK: begin
          pos_n = dec;
          if (d == fwd) begin
            miss_n = '0;
          end else if (d == rev) begin
            dir_n  = ~dir_q;
            dchg_n = 1'b1;
            miss_n = '0;
          end else begin
            err_n = 1'b1;
            if (errc_q != '1) errc_n = errc_q + 1'b1;
            if (miss_inc == MISS_MAX4) begin
              miss_n  = '0;
              cnt_n   = '0;
              state_n = S_HUNT;
            end else begin
              miss_n = miss_inc;
            end
          end
        end
        default: state_n = S_HUNT;
      endcase
`ifdef LR2_TRK_LOAD_EN
      end
`endif
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_HUNT;
      pos_q   <= '0;
      dir_q   <= 1'b1;
      err_q   <= 1'b0;
      dchg_q  <= 1'b0;
      errc_q  <= '0;
      cnt_q   <= '0;
      miss_q  <= '0;
    end else begin
      state_q <= state_n;
      pos_q   <= pos_n;
      dir_q   <= dir_n;
      err_q   <= err_n;
      dchg_q  <= dchg_n;
      errc_q  <= errc_n;
      cnt_q   <= cnt_n;
      miss_q  <= miss_n;
    end
  end

  assign POS     = pos_q;
  assign DIR     = dir_q;
  assign LOCK    = (state_q == S_LOCK);
  assign ERR     = err_q;
  assign DIR_CHG = dchg_q;
  assign ERR_CNT = errc_q;

endmodule

// File: tb/tb_lr2_seq_tracker_fsm.sv
// Directed self-checking bench for lr2_seq_tracker_fsm (LR2_OUT taken as reflected Gray code).
module tb_lr2_seq_tracker_fsm;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       CE = 1'b0;
  logic [3:0] SEQ = 4'h0;
  logic       SYNC_REQ = 1'b0;
  logic       LOAD = 1'b0;
  logic [3:0] POS;
  logic       DIR;
  logic       LOCK;
  logic       ERR;
  logic       DIR_CHG;
  logic [7:0] ERR_CNT;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  lr2_seq_tracker_fsm #(.LOCK_CNT(2), .MISS_MAX(3), .ERRW(8)) dut (
    .CLK(CLK), .RST(RST), .CE(CE), .SEQ(SEQ), .SYNC_REQ(SYNC_REQ),
`ifdef LR2_TRK_LOAD_EN
    .LOAD(LOAD),
`endif
    .POS(POS), .DIR(DIR), .LOCK(LOCK), .ERR(ERR), .DIR_CHG(DIR_CHG), .ERR_CNT(ERR_CNT)
  );

  function automatic logic [3:0] out_enc(input logic [3:0] n);
    return n ^ {1'b0, n[3:1]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One CE sample; outputs are examined 1 time unit after the capturing edge.
  task automatic step(input logic [3:0] n);
    @(negedge CLK);
    CE  = 1'b1;
    SEQ = out_enc(n);
    @(posedge CLK);
    #1;
    CE = 1'b0;
  endtask

  task automatic idle();
    @(posedge CLK);
    #1;
  endtask

  logic [3:0] p;
  logic [3:0] q;

  initial begin
    // reset
    repeat (2) idle();
    @(negedge CLK); RST = 1'b0;
    #1;
    check("rst_pos", 32'(POS), 32'h0);
    check("rst_dir", 32'(DIR), 32'h1);
    check("rst_lock", 32'(LOCK), 32'h0);
    check("rst_err", 32'(ERR), 32'h0);
    check("rst_dchg", 32'(DIR_CHG), 32'h0);
    check("rst_errcnt", 32'(ERR_CNT), 32'h0);

    // acquisition up 3,4,5
    step(4'h3); check("t1_pos3", 32'(POS), 32'h3); check("t1_lock_a", 32'(LOCK), 32'h0);
    step(4'h4); check("t1_lock_b", 32'(LOCK), 32'h0);
    step(4'h5);
    check("t1_lock", 32'(LOCK), 32'h1);
    check("t1_pos", 32'(POS), 32'h5);
    check("t1_dir", 32'(DIR), 32'h1);
    check("t1_errcnt", 32'(ERR_CNT), 32'h0);
    idle(); idle();
    check("hold_pos", 32'(POS), 32'h5);

    // single error then recovery
    step(4'h9);
    check("t3_err", 32'(ERR), 32'h1);
    check("t3_errcnt", 32'(ERR_CNT), 32'h1);
    check("t3_pos", 32'(POS), 32'h9);
    check("t3_lock", 32'(LOCK), 32'h1);
    idle();
    check("t3_err_pulse", 32'(ERR), 32'h0);
    step(4'hA);
    check("t3_noerr", 32'(ERR), 32'h0);

    // wrap up through F->0 then reverse
    step(4'hB); step(4'hC); step(4'hD); step(4'hE);
    step(4'hF); check("t2_err_f", 32'(ERR), 32'h0);
    step(4'h0); check("t2_err_0", 32'(ERR), 32'h0);
    step(4'h1); check("t2_err_1", 32'(ERR), 32'h0);
    check("t2_pos1", 32'(POS), 32'h1);
    step(4'h0);
    check("t2_dchg", 32'(DIR_CHG), 32'h1);
    check("t2_dir", 32'(DIR), 32'h0);
    check("t2_err_rev", 32'(ERR), 32'h0);
    step(4'hF);
    check("t2_dchg_once", 32'(DIR_CHG), 32'h0);
    check("t2_posF", 32'(POS), 32'hF);
    check("t2_lock", 32'(LOCK), 32'h1);

    // three consecutive misses drop lock; relock
    step(4'h2); check("t4_err1", 32'(ERR), 32'h1);
    step(4'h8); check("t4_lock2", 32'(LOCK), 32'h1);
    step(4'hC);
    check("t4_err3", 32'(ERR), 32'h1);
    check("t4_lock", 32'(LOCK), 32'h0);
    check("t4_errcnt", 32'(ERR_CNT), 32'h4);
    step(4'hD); step(4'hE); step(4'hF);
    check("t4_relock", 32'(LOCK), 32'h1);
    check("t4_pos", 32'(POS), 32'hF);
    check("t4_dir", 32'(DIR), 32'h1);

    // d=0 in LOCK is an error
    step(4'h0);
    step(4'h0);
    check("d0_err", 32'(ERR), 32'h1);
    check("d0_errcnt", 32'(ERR_CNT), 32'h5);
    step(4'h1);
    check("d0_noerr", 32'(ERR), 32'h0);

    // drive ERR_CNT to saturation
    p = 4'h1;
    for (int i = 0; i < 250; i++) begin
      p = p + 4'h8;
      step(p);
      check("sat_err", 32'(ERR), 32'h1);
      p = p + 4'h1;
      step(p);
    end
    check("sat_ff", 32'(ERR_CNT), 32'hFF);
    check("sat_lock", 32'(LOCK), 32'h1);
    q = p + 4'h8;
    step(q);
    check("t5_err", 32'(ERR), 32'h1);
    check("t5_errcnt", 32'(ERR_CNT), 32'hFF);

    // SYNC_REQ wins over concurrent CE
    @(negedge CLK);
    CE = 1'b1; SYNC_REQ = 1'b1; SEQ = out_enc(q + 4'h1);
    @(posedge CLK); #1;
    CE = 1'b0; SYNC_REQ = 1'b0;
    check("t5_lock", 32'(LOCK), 32'h0);
    check("t5_pos", 32'(POS), 32'(q));
    check("t5_errcnt2", 32'(ERR_CNT), 32'hFF);
    check("t5_dir", 32'(DIR), 32'h1);

    // ACQ/CONF corner cases: d=0 ignored, jump restarts, lock downward
    step(4'h7); check("acq_pos", 32'(POS), 32'h7);
    step(4'h7); check("acq_d0", 32'(POS), 32'h7);
    step(4'h2); check("acq_jump", 32'(POS), 32'h2);
    step(4'h1); check("conf_dir", 32'(DIR), 32'h0);
    step(4'h1); check("conf_d0", 32'(LOCK), 32'h0);
    step(4'h0);
    check("down_lock", 32'(LOCK), 32'h1);
    check("down_pos", 32'(POS), 32'h0);
    check("down_err", 32'(ERR), 32'h0);

    // reset mid-lock
    @(negedge CLK); RST = 1'b1;
    @(posedge CLK); #1;
    @(negedge CLK); RST = 1'b0;
    check("rst2_lock", 32'(LOCK), 32'h0);
    check("rst2_pos", 32'(POS), 32'h0);
    check("rst2_dir", 32'(DIR), 32'h1);
    check("rst2_errcnt", 32'(ERR_CNT), 32'h0);

    // LOAD jump while locked at 2
    step(4'h0); step(4'h1); step(4'h2);
    check("t6_lock", 32'(LOCK), 32'h1);
    @(negedge CLK);
    CE = 1'b1; LOAD = 1'b1; SEQ = out_enc(4'hB);
    @(posedge CLK); #1;
    CE = 1'b0; LOAD = 1'b0;
    check("t6_pos", 32'(POS), 32'hB);
    check("t6_lock_after", 32'(LOCK), 32'h1);
`ifdef LR2_TRK_LOAD_EN
    check("t6_err", 32'(ERR), 32'h0);
    check("t6_errcnt", 32'(ERR_CNT), 32'h0);
`else
    check("t6_err", 32'(ERR), 32'h1);
    check("t6_errcnt", 32'(ERR_CNT), 32'h1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
